// File: rtl/fetch_pc_stack_if.sv
// Control/fetch bundle between the control unit and the PC/return stack.
// Master drives controls; slave returns pc and stack status.
interface fetch_pc_stack_if #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic          en;
    logic          s_inc;
    logic          push;
    logic          pop;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
    logic [SPW-1:0] sp;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_err;

    modport master (
        output en, s_inc, push, pop, jump_addr,
        input  pc, sp, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  en, s_inc, push, pop, jump_addr,
        output pc, sp, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/fetch_pc_stack.sv
// Fetch program counter with a LIFO return-address stack.
// One action per enabled edge; sticky error on illegal/over/underflow.
module fetch_pc_stack #(
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input logic             clk,
    input logic             reset,
    fetch_pc_stack_if.slave bus
);
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int IW  = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_ILL,
        OP_CALL,
        OP_OVF,
        OP_RET,
        OP_UNF,
        OP_SEQ,
        OP_JMP
    } op_e;

    logic [AW-1:0]  pc_q;
    logic [AW-1:0]  pc_d;
    logic [AW-1:0]  pc_inc;
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_d;
    logic [SPW-1:0] sp_m1;
    logic           err_q;
    logic           err_d;
    logic           full;
    logic           empty;
    logic           wr_en;
    op_e            op;

    logic [AW-1:0]  stack_mem [DEPTH];

    assign pc_inc = pc_q + 1'b1;
    assign sp_m1  = sp_q - 1'b1;
    assign full   = (sp_q == SP_FULL);
    assign empty  = (sp_q == '0);

    // Priority decode of the control word into a single action.
    always_comb begin
        op = OP_HOLD;
        if (bus.en) begin
            unique case (1'b1)
                bus.push && bus.pop:
                    op = OP_ILL;
                bus.push && !bus.pop:
                    op = full ? OP_OVF : OP_CALL;
                !bus.push && bus.pop:
                    op = empty ? OP_UNF : OP_RET;
                !bus.push && !bus.pop && bus.s_inc:
                    op = OP_SEQ;
                default:
                    op = OP_JMP;
            endcase
        end
    end

    // Next-state values for pc, sp and the sticky error flag.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        wr_en = 1'b0;
        unique case (op)
            OP_ILL: begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end
            OP_CALL: begin
                pc_d  = bus.jump_addr;
                sp_d  = sp_q + 1'b1;
                wr_en = 1'b1;
            end
            OP_OVF: begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end
            OP_RET: begin
                pc_d = stack_mem[sp_m1[IW-1:0]];
                sp_d = sp_m1;
            end
            OP_UNF: begin
                pc_d  = pc_inc;
                err_d = 1'b1;
            end
            OP_SEQ: pc_d = pc_inc;
            OP_JMP: pc_d = bus.jump_addr;
            default: ;
        endcase
    end

    // Architectural state; reset clears it at once, independent of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; not cleared, writes blocked while in reset.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            stack_mem[sp_q[IW-1:0]] <= pc_inc;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sp          = sp_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_fetch_pc_stack.sv
// Self-checking bench for fetch_pc_stack: vector table, corner
// sequences and random stimulus against a queue-based model.
module tb_fetch_pc_stack;
    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int MASK  = (1 << AW) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_pc_stack_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    fetch_pc_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          s_inc;
        logic          push;
        logic          pop;
        logic [AW-1:0] ja;
        logic [AW-1:0] epc;
        int            esp;
        bit            eerr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain integer pc, a queue as the stack.
    int unsigned m_pc;
    int unsigned m_stk[$];
    bit          m_err;

    task automatic model_reset();
        m_pc  = 0;
        m_stk.delete();
        m_err = 0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit pu,
                              input bit po, input int unsigned ja);
        int unsigned nxt;
        nxt = (m_pc + 1) & MASK;
        if (!e) return;
        if (pu && po) begin
            m_pc  = nxt;
            m_err = 1;
        end else if (pu) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(nxt);
                m_pc = ja & MASK;
            end else begin
                m_pc  = nxt;
                m_err = 1;
            end
        end else if (po) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc  = nxt;
                m_err = 1;
            end
        end else if (s) begin
            m_pc = nxt;
        end else begin
            m_pc = ja & MASK;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int epc,
                             input int esp, input bit eerr);
        chk({tag, ".pc"}, int'(bus.pc), epc);
        chk({tag, ".sp"}, int'(bus.sp), esp);
        chk({tag, ".err"}, int'(bus.stack_err), int'(eerr));
        chk({tag, ".full"}, int'(bus.stack_full), int'(esp == DEPTH));
        chk({tag, ".empty"}, int'(bus.stack_empty), int'(esp == 0));
    endtask

    task automatic drive(input bit e, input bit s, input bit pu,
                         input bit po, input int unsigned ja);
        bus.en        = e;
        bus.s_inc     = s;
        bus.push      = pu;
        bus.pop       = po;
        bus.jump_addr = AW'(ja);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit e, input bit s, input bit pu,
                        input bit po, input int unsigned ja);
        drive(e, s, pu, po, ja);
        model_step(e, s, pu, po, ja);
        tick();
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        int unsigned ret [DEPTH];
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(0, 1, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Directed vector table
        vecs.push_back('{1, 1, 0, 0, 10'h000, 10'h001, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 10'h000, 10'h002, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 10'h000, 10'h003, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 10'h3FF, 10'h3FF, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 10'h123, 10'h000, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 10'h005, 10'h005, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 10'h040, 10'h040, 1, 0});
        vecs.push_back('{1, 1, 0, 0, 10'h000, 10'h041, 1, 0});
        vecs.push_back('{1, 0, 0, 1, 10'h2AA, 10'h006, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 10'h010, 10'h010, 0, 0});
        vecs.push_back('{1, 1, 0, 1, 10'h000, 10'h011, 0, 1});
        vecs.push_back('{1, 0, 0, 0, 10'h020, 10'h020, 0, 1});
        vecs.push_back('{1, 0, 1, 1, 10'h155, 10'h021, 0, 1});
        vecs.push_back('{1, 1, 1, 0, 10'h080, 10'h080, 1, 1});
        vecs.push_back('{0, 1, 1, 0, 10'h099, 10'h080, 1, 1});
        vecs.push_back('{0, 1, 1, 0, 10'h099, 10'h080, 1, 1});
        vecs.push_back('{0, 1, 1, 0, 10'h099, 10'h080, 1, 1});
        vecs.push_back('{0, 0, 0, 1, 10'h000, 10'h080, 1, 1});
        vecs.push_back('{1, 0, 0, 1, 10'h000, 10'h022, 0, 1});
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].s_inc, vecs[i].push,
                  vecs[i].pop, vecs[i].ja);
            tick();
            check_all($sformatf("vec%0d", i), int'(vecs[i].epc),
                      vecs[i].esp, vecs[i].eerr);
        end

        // Nested calls up to full, overflow, then LIFO unwind
        do_reset();
        check_all("ovf.rst", 0, 0, 0);
        drive(1, 0, 0, 0, 'h100);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            ret[i] = (i == 0) ? 'h101 : ('h201 + (i - 1) * 'h10);
            drive(1, 0, 1, 0, 'h200 + i * 'h10);
            tick();
            check_all($sformatf("call%0d", i), 'h200 + i * 'h10,
                      i + 1, 0);
        end
        drive(1, 0, 1, 0, 'h3AB);
        tick();
        check_all("ovf", 'h271, DEPTH, 1);
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 0, 0, 1, 'h3CC);
            tick();
            check_all($sformatf("ret%0d", k), int'(ret[DEPTH-1-k]),
                      DEPTH - 1 - k, 1);
        end

        // Asynchronous reset between edges, mid-call
        do_reset();
        drive(1, 0, 1, 0, 'h0A0);
        tick();
        drive(1, 0, 1, 0, 'h0B0);
        tick();
        drive(1, 0, 1, 1, 0);
        tick();
        check_all("pre_rst", 'h0B1, 2, 1);
        drive(1, 0, 1, 0, 'h0C0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all("rst_discard", 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        tick();
        check_all("rst_resume", 1, 0, 0);

        // Randomized run against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit e, s, pu, po;
            if ($urandom_range(0, 199) == 0) do_reset();
            e  = ($urandom_range(0, 7) != 0);
            s  = $urandom_range(0, 1) == 1;
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            step(e, s, pu, po, $urandom);
            check_all($sformatf("rnd%0d", n), int'(m_pc),
                      m_stk.size(), m_err);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_stack.md
FETCH_PC_STACK -- requirements
Module: fetch_pc_stack

Interface
REQ-001 SHALL have parameter AW, default 10, program-counter and return-address width.
REQ-002 SHALL have parameter DEPTH, default 8, return-stack entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 SHALL have port en  input  1  advance enable; 0 holds all state.
REQ-006 SHALL have port s_inc  input  1  from control unit; 1 = sequential, 0 = jump.
REQ-007 SHALL have port push  input  1  from control unit; subroutine call.
REQ-008 SHALL have port pop  input  1  from control unit; subroutine return.
REQ-009 SHALL have port jump_addr  input  AW  target address, from instruction field.
REQ-010 SHALL have port pc  output  AW  current fetch address to instruction memory.
REQ-011 SHALL have port sp  output  $clog2(DEPTH)+1  number of valid stack entries.
REQ-012 SHALL have port stack_full  output  1  sp == DEPTH, combinational from sp.
REQ-013 SHALL have port stack_empty  output  1  sp == 0, combinational from sp.
REQ-014 SHALL have port stack_err  output  1  sticky error flag.

Function
REQ-015 SHALL evaluate one action per rising edge only when en=1; with en=0, pc, sp, stack contents and stack_err hold.
REQ-016 SHALL decode with this priority: (push&pop) > push > pop > s_inc.
REQ-017 SHALL, on push=pop=1, perform an illegal-operation action: pc <= pc+1, stack unchanged, stack_err <= 1.
REQ-018 SHALL, on push=1 with sp<DEPTH, write pc+1 (mod 2^AW) into entry sp, increment sp, and set pc <= jump_addr, all in the same edge.
REQ-019 SHALL, on push=1 with sp==DEPTH (overflow), leave stack and sp unchanged, set pc <= pc+1, and set stack_err <= 1.
REQ-020 SHALL, on pop=1 with sp>0, set pc <= entry sp-1 and decrement sp in the same edge.
REQ-021 SHALL, on pop=1 with sp==0 (underflow), leave sp unchanged, set pc <= pc+1, and set stack_err <= 1.
REQ-022 SHALL, with push=pop=0: pc <= pc+1 when s_inc=1, and pc <= jump_addr when s_inc=0.
REQ-023 SHALL compute pc+1 modulo 2^AW (all-ones wraps to 0) with no flag.
REQ-024 SHALL have a single-cycle latency: the new pc is visible on the output after the edge that consumed the controls, and no bubble is inserted.
REQ-025 SHALL register pc directly with no combinational path from inputs to pc.
REQ-026 SHALL clear stack_err only by reset.
REQ-027 SHALL have entries at index >= sp that are don't-care and never readable via pc.

Reset
REQ-028 SHALL, while reset=0, force pc=0, sp=0, stack_err=0 (stack_empty=1, stack_full=0) asynchronously, regardless of clk and en.
REQ-029 SHALL resume normal operation on the first rising edge after reset returns to 1; an assertion mid-call or mid-return discards that operation.
REQ-030 SHALL NOT require clearing of stack storage on reset.

Verification
REQ-031 SHALL be covered by a sequential test: after reset, s_inc=1 for 3 edges -> pc 0,1,2,3; then s_inc=0, jump_addr=0x3FF, then s_inc=1 -> pc 0x3FF, then wraps to 0x000.
REQ-032 SHALL be covered by a call/return test: pc=5, push with jump_addr=0x40 -> pc=0x40, sp=1; one s_inc -> pc=0x41; pop -> pc=6, sp=0, stack_err=0.
REQ-033 SHALL be covered by a nested-overflow test: DEPTH=8 pushes -> sp=8, stack_full=1; 9th push at pc=p -> pc=p+1, sp=8, stack_err=1; 8 pops return addresses in LIFO order.
REQ-034 SHALL be covered by underflow and illegal tests: pop at sp=0, pc=0x10 -> pc=0x11, stack_err=1; push=pop=1 at pc=0x20 -> pc=0x21, sp unchanged.
REQ-035 SHALL be covered by stall and reset tests: en=0 with push=1 for 3 edges -> pc and sp unchanged; reset=0 asserted between edges mid-sequence -> pc=0, sp=0, stack_err=0 immediately, before the next edge.
